// File: rtl/ins_serializer.sv
// ins_serializer: transmit side of cpum's 1-bit `ins` instruction line.
// Host bytes are queued in a DEPTH-entry FIFO and framed out as
// start bit (1), eight data bits MSB-first, optional parity bit, and
// GAP_CYCLES low cycles. Back-to-back frames are separated by exactly
// GAP_CYCLES low cycles.
//
// Build option: define INS_PARITY_EN to insert an even-parity bit
// (XOR of the 8 data bits) after data bit 0. Without it the frame is
// cpum's default 9-bit framing.
//
// state  | meaning
// IDLE   | line low, waiting for FIFO to hold a byte
// START  | start bit (ins=1) for one cycle
// DATA   | eight data bits, MSB first, from the shift register
// PARITY | even parity bit (INS_PARITY_EN builds only)
// GAP    | GAP_CYCLES low cycles; frame_done on the last one

module ins_serializer #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic                     ins,
  output logic                     busy,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef INS_PARITY_EN
    S_PARITY,
`endif
    S_GAP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // FSM and registered outputs
  state_t        state_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          ins_q;
  logic          busy_q;
  logic          frame_done_q;
`ifdef INS_PARITY_EN
  logic          parity_q;
`endif

  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic       gap_end;
  logic [7:0] head_byte;

  // Write acceptance comes from the registered count only, so a full FIFO
  // refuses a byte even in the cycle the FSM pops.
  assign wr_ready   = (count_q != FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = wr_valid && wr_ready;
  assign gap_end    = (state_q == S_GAP) && (gap_cnt_q == '0);
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || gap_end);
  assign head_byte  = mem_q[rd_ptr_q];

  assign ins        = ins_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign count      = count_q;

  // Next pointer/occupancy values; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Frame sequencer: every output is registered and set on entry to the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ins_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef INS_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ins_q  <= 1'b0;
          busy_q <= 1'b0;
          if (pop) begin
            state_q <= S_START;
            shreg_q <= head_byte;
            ins_q   <= 1'b1;
            busy_q  <= 1'b1;
`ifdef INS_PARITY_EN
            parity_q <= ^head_byte;
`endif
          end
        end

        S_START: begin
          state_q   <= S_DATA;
          bit_cnt_q <= 3'd7;
          ins_q     <= shreg_q[7];
          shreg_q   <= {shreg_q[6:0], 1'b0};
        end

        S_DATA: begin
          if (bit_cnt_q == 3'd0) begin
`ifdef INS_PARITY_EN
            state_q <= S_PARITY;
            ins_q   <= parity_q;
`else
            state_q      <= S_GAP;
            ins_q        <= 1'b0;
            gap_cnt_q    <= GAP_LAST;
            frame_done_q <= (GAP_LAST == '0);
`endif
          end else begin
            bit_cnt_q <= bit_cnt_q - 3'd1;
            ins_q     <= shreg_q[7];
            shreg_q   <= {shreg_q[6:0], 1'b0};
          end
        end

`ifdef INS_PARITY_EN
        S_PARITY: begin
          state_q      <= S_GAP;
          ins_q        <= 1'b0;
          gap_cnt_q    <= GAP_LAST;
          frame_done_q <= (GAP_LAST == '0);
        end
`endif

        S_GAP: begin
          ins_q <= 1'b0;
          if (gap_cnt_q == '0) begin
            if (pop) begin
              state_q <= S_START;
              shreg_q <= head_byte;
              ins_q   <= 1'b1;
              busy_q  <= 1'b1;
`ifdef INS_PARITY_EN
              parity_q <= ^head_byte;
`endif
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_cnt_q    <= gap_cnt_q - GW'(1);
            frame_done_q <= (gap_cnt_q == GAP_ONE);
          end
        end

        default: begin
          state_q <= S_IDLE;
          ins_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_serializer.sv
// Directed bench for ins_serializer (DEPTH=8, GAP_CYCLES=1).
// Inputs are driven and outputs sampled on the falling clock edge.
// With INS_PARITY_EN defined the frame checker also expects the parity bit.

module tb_ins_serializer;

  localparam int DEPTH = 8;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       ins;
  logic       busy;
  logic       frame_done;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;
  int fd_cnt   = 0;
  int fd0;

  ins_serializer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .ins        (ins),
    .busy       (busy),
    .frame_done (frame_done),
    .count      (count)
  );

  always #5 clk = ~clk;

  // frame_done pulse counter
  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge where the start bit should be visible;
  // returns at the falling edge of the last gap cycle.
  task automatic frame(input logic [7:0] b, input string tag);
    chk({tag, "_start"}, {31'd0, ins}, 32'd1);
    chk({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_start_fd"}, {31'd0, frame_done}, 32'd0);
    for (int i = 7; i >= 0; i--) begin
      tick();
      wr_valid = 1'b0;
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, ins}, {31'd0, b[i]});
    end
`ifdef INS_PARITY_EN
    tick();
    chk({tag, "_parity"}, {31'd0, ins}, {31'd0, ^b});
`endif
    for (int g = 0; g < GAP; g++) begin
      tick();
      chk($sformatf("%s_gap%0d", tag, g), {31'd0, ins}, 32'd0);
      chk($sformatf("%s_gap%0d_busy", tag, g), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_gap%0d_fd", tag, g), {31'd0, frame_done}, (g == GAP - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    // T1: reset held with wr_valid asserted
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    repeat (3) tick();
    chk("t1_ins", {31'd0, ins}, 32'd0);
    chk("t1_count", {28'd0, count}, 32'd0);
    chk("t1_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_fd", {31'd0, frame_done}, 32'd0);
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    tick();
    chk("t1_idle_count", {28'd0, count}, 32'd0);

    // T2: single byte 8'hA5
    fd0      = fd_cnt;
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("t2_count_after_accept", {28'd0, count}, 32'd1);
    chk("t2_ins_latency", {31'd0, ins}, 32'd0);
    chk("t2_busy_latency", {31'd0, busy}, 32'd0);
    tick();
    chk("t2_count_after_pop", {28'd0, count}, 32'd0);
    frame(8'hA5, "t2_a5");
    tick();
    chk("t2_busy_end", {31'd0, busy}, 32'd0);
    chk("t2_ins_end", {31'd0, ins}, 32'd0);
    chk("t2_fd_end", {31'd0, frame_done}, 32'd0);
    chk("t2_fd_pulses", fd_cnt - fd0, 32'd1);

    // T3: burst 01, 80, FF back-to-back
    fd0      = fd_cnt;
    wr_data  = 8'h01;
    wr_valid = 1'b1;
    tick();
    wr_data  = 8'h80;
    tick();
    chk("t3_count_pop_push", {28'd0, count}, 32'd1);
    wr_data  = 8'hFF;
    frame(8'h01, "t3_01");
    tick();
    frame(8'h80, "t3_80");
    tick();
    frame(8'hFF, "t3_ff");
    tick();
    chk("t3_busy_end", {31'd0, busy}, 32'd0);
    chk("t3_fd_pulses", fd_cnt - fd0, 32'd3);

    // T4: fill past DEPTH; bytes 10..1B offered on consecutive cycles
    fd0 = fd_cnt;
    for (int k = 1; k <= 12; k++) begin
      wr_data  = 8'h0F + 8'(k);
      wr_valid = 1'b1;
      tick();
      if (k == 9) begin
        chk("t4_count_full", {28'd0, count}, 32'd8);
        chk("t4_wr_ready_full", {31'd0, wr_ready}, 32'd0);
      end
      if (k == 10) chk("t4_count_still_full", {28'd0, count}, 32'd8);
      if (k == 12) begin
        chk("t4_count_pop_at_full", {28'd0, count}, 32'd7);
        chk("t4_wr_ready_after_pop", {31'd0, wr_ready}, 32'd1);
      end
    end
    wr_valid = 1'b0;
    frame(8'h11, "t4_11");
    for (int b = 8'h12; b <= 8'h18; b++) begin
      tick();
      frame(8'(b), $sformatf("t4_%0h", b));
    end
    tick();
    chk("t4_busy_end", {31'd0, busy}, 32'd0);
    chk("t4_count_end", {28'd0, count}, 32'd0);
    chk("t4_fd_pulses", fd_cnt - fd0, 32'd9);

    // T5: reset during bit 4 of 8'hC3 with 8'h5A queued
    fd0      = fd_cnt;
    wr_data  = 8'hC3;
    wr_valid = 1'b1;
    tick();
    wr_data  = 8'h5A;
    tick();
    wr_valid = 1'b0;
    chk("t5_start", {31'd0, ins}, 32'd1);
    chk("t5_count_queued", {28'd0, count}, 32'd1);
    repeat (4) tick();
    chk("t5_bit4", {31'd0, ins}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_ins", {31'd0, ins}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_count", {28'd0, count}, 32'd0);
    chk("t5_rst_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t5_flushed_busy", {31'd0, busy}, 32'd0);
    chk("t5_flushed_ins", {31'd0, ins}, 32'd0);
    chk("t5_no_fd", fd_cnt - fd0, 32'd0);
    wr_data  = 8'h3C;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    frame(8'h3C, "t5_3c");
    tick();
    chk("t5_busy_end", {31'd0, busy}, 32'd0);

`ifdef INS_PARITY_EN
    // T6: parity build, 8'h07 then 8'h03
    fd0      = fd_cnt;
    wr_data  = 8'h07;
    wr_valid = 1'b1;
    tick();
    wr_data  = 8'h03;
    tick();
    wr_valid = 1'b0;
    frame(8'h07, "t6_07");
    tick();
    frame(8'h03, "t6_03");
    tick();
    chk("t6_busy_end", {31'd0, busy}, 32'd0);
    chk("t6_fd_pulses", fd_cnt - fd0, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
